// File: rtl/mem_bridge_if.sv
// mem_bridge_if: fetch/load-store request ports and word-addressed memory bus
interface mem_bridge_if;
  logic        ifu_reqValid;
  logic [31:0] ifu_addr;
  logic        ifu_respValid;
  logic [31:0] ifu_rdata;
  logic        ifu_err;
  logic        lsu_reqValid;
  logic [31:0] lsu_addr;
  logic [1:0]  lsu_size;
  logic        lsu_wen;
  logic [31:0] lsu_wdata;
  logic [3:0]  lsu_wmask;
  logic        lsu_respValid;
  logic [31:0] lsu_rdata;
  logic        lsu_err;
  logic        mem_reqValid;
  logic        mem_reqReady;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_respValid;
  logic [31:0] mem_rdata;
  modport master (
    input  ifu_reqValid, ifu_addr, lsu_reqValid, lsu_addr, lsu_size, lsu_wen, lsu_wdata, lsu_wmask,
           mem_reqReady, mem_respValid, mem_rdata,
    output ifu_respValid, ifu_rdata, ifu_err, lsu_respValid, lsu_rdata, lsu_err,
           mem_reqValid, mem_addr, mem_wen, mem_wdata, mem_wstrb
  );
  modport slave (
    output ifu_reqValid, ifu_addr, lsu_reqValid, lsu_addr, lsu_size, lsu_wen, lsu_wdata, lsu_wmask,
           mem_reqReady, mem_respValid, mem_rdata,
    input  ifu_respValid, ifu_rdata, ifu_err, lsu_respValid, lsu_rdata, lsu_err,
           mem_reqValid, mem_addr, mem_wen, mem_wdata, mem_wstrb
  );
endinterface

// File: rtl/mem_bridge.sv
// mem_bridge: arbitrates ifu/lsu requests onto one word bus, one transaction at a time
module mem_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter bit          LSU_PRIORITY   = 1'b1
) (
  input logic          clock,
  input logic          reset,
  mem_bridge_if.master bus
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
  state_t      state_q;
  logic        lsu_q, wen_q;
  logic [1:0]  off_q, size_q;
  logic [31:0] cnt_q;
  logic        ifu_resp_q, lsu_resp_q, ifu_err_q, lsu_err_q, mem_req_q, mem_wen_q;
  logic [31:0] ifu_rdata_q, lsu_rdata_q, mem_addr_q, mem_wdata_q;
  logic [3:0]  mem_wstrb_q;
  logic        grant_lsu_d, misaligned_d, timeout_d;
  logic [31:0] req_addr_d, shifted_d, rdata_d;

  assign bus.ifu_respValid = ifu_resp_q;
  assign bus.ifu_rdata     = ifu_rdata_q;
  assign bus.ifu_err       = ifu_err_q;
  assign bus.lsu_respValid = lsu_resp_q;
  assign bus.lsu_rdata     = lsu_rdata_q;
  assign bus.lsu_err       = lsu_err_q;
  assign bus.mem_reqValid  = mem_req_q;
  assign bus.mem_addr      = mem_addr_q;
  assign bus.mem_wen       = mem_wen_q;
  assign bus.mem_wdata     = mem_wdata_q;
  assign bus.mem_wstrb     = mem_wstrb_q;

  // grant selection, alignment check, right-aligned read data and timeout detect
  always_comb begin
    grant_lsu_d  = bus.lsu_reqValid && (LSU_PRIORITY || !bus.ifu_reqValid);
    req_addr_d   = grant_lsu_d ? bus.lsu_addr : bus.ifu_addr;
    misaligned_d = grant_lsu_d ? (bus.lsu_size == 2'd3 || (bus.lsu_size == 2'd1 && req_addr_d[0]) ||
                                  (bus.lsu_size == 2'd2 && |req_addr_d[1:0])) : |req_addr_d[1:0];
    shifted_d    = bus.mem_rdata >> {off_q, 3'b000};
    rdata_d      = !lsu_q ? bus.mem_rdata : wen_q ? 32'd0 :
                   size_q == 2'd0 ? {24'd0, shifted_d[7:0]} :
                   size_q == 2'd1 ? {16'd0, shifted_d[15:0]} : shifted_d;
    timeout_d    = TIMEOUT_CYCLES != 0 && cnt_q == TIMEOUT_CYCLES - 1;
  end

  // transaction FSM; every output is a register updated here
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      lsu_q       <= 1'b0;
      wen_q       <= 1'b0;
      off_q       <= 2'd0;
      size_q      <= 2'd0;
      cnt_q       <= 32'd0;
      ifu_resp_q  <= 1'b0;
      lsu_resp_q  <= 1'b0;
      ifu_err_q   <= 1'b0;
      lsu_err_q   <= 1'b0;
      ifu_rdata_q <= 32'd0;
      lsu_rdata_q <= 32'd0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wen_q   <= 1'b0;
      mem_wdata_q <= 32'd0;
      mem_wstrb_q <= 4'd0;
    end else begin
      case (state_q)
        IDLE: if (bus.ifu_reqValid || bus.lsu_reqValid) begin
          lsu_q       <= grant_lsu_d;
          wen_q       <= grant_lsu_d && bus.lsu_wen;
          off_q       <= req_addr_d[1:0];
          size_q      <= bus.lsu_size;
          mem_addr_q  <= {req_addr_d[31:2], 2'b00};
          mem_wen_q   <= grant_lsu_d && bus.lsu_wen;
          mem_wdata_q <= bus.lsu_wdata;
          mem_wstrb_q <= grant_lsu_d && bus.lsu_wen ? bus.lsu_wmask << req_addr_d[1:0] : 4'd0;
          mem_req_q   <= !misaligned_d;
          ifu_resp_q  <= misaligned_d && !grant_lsu_d;
          ifu_err_q   <= misaligned_d && !grant_lsu_d;
          lsu_resp_q  <= misaligned_d && grant_lsu_d;
          lsu_err_q   <= misaligned_d && grant_lsu_d;
          state_q     <= misaligned_d ? RESP : REQ;
        end
        REQ: if (bus.mem_reqReady) begin
          mem_req_q <= 1'b0;
          cnt_q     <= 32'd0;
          state_q   <= WAIT;
        end
        WAIT: if (bus.mem_respValid || timeout_d) begin
          state_q     <= RESP;
          ifu_resp_q  <= !lsu_q;
          lsu_resp_q  <= lsu_q;
          ifu_err_q   <= !lsu_q && !bus.mem_respValid;
          lsu_err_q   <= lsu_q && !bus.mem_respValid;
          ifu_rdata_q <= !lsu_q && bus.mem_respValid ? rdata_d : 32'd0;
          lsu_rdata_q <= lsu_q && bus.mem_respValid ? rdata_d : 32'd0;
        end else begin
          cnt_q <= cnt_q + 32'd1;
        end
        RESP: begin
          state_q     <= IDLE;
          ifu_resp_q  <= 1'b0;
          lsu_resp_q  <= 1'b0;
          ifu_err_q   <= 1'b0;
          lsu_err_q   <= 1'b0;
          ifu_rdata_q <= 32'd0;
          lsu_rdata_q <= 32'd0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_bridge.sv
// tb_mem_bridge: directed and randomized transactions against a transaction-level model
module tb_mem_bridge;
  localparam int TO = 4;
  logic clock = 1'b0;
  logic reset = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clock = ~clock;

  mem_bridge_if bus ();
  mem_bridge #(.TIMEOUT_CYCLES(TO), .LSU_PRIORITY(1'b1)) dut (.clock(clock), .reset(reset), .bus(bus));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // one transaction: model computes outcome from address/size/delays, bench plays core and memory
  task automatic txn(input bit is_lsu, input bit keep_other, input logic [31:0] addr, input logic [1:0] size,
                     input bit wen, input logic [31:0] wdata, input logic [31:0] mrdata,
                     input int rdy_dly, input int rsp_dly);
    int nb, lat, reqc, waitc, memreqs, off;
    bit bad, tmo, hs, done, req_seen, rdy_drv, st;
    logic [3:0] wm, strb;
    logic [31:0] sh, exp_rd;
    off = int'(addr[1:0]);
    nb  = !is_lsu ? 4 : size == 2'd0 ? 1 : size == 2'd1 ? 2 : 4;
    wm  = nb == 1 ? 4'b0001 : nb == 2 ? 4'b0011 : 4'b1111;
    bad = is_lsu ? (size == 2'd3 || off % nb != 0) : off != 0;
    tmo = rsp_dly >= TO;
    st  = is_lsu && wen;
    for (int i = 0; i < 4; i++) strb[i] = st && i >= off && i < off + nb;
    sh     = mrdata >> (8 * off);
    exp_rd = (bad || tmo) ? 32'd0 : !is_lsu ? mrdata : wen ? 32'd0 : nb == 4 ? sh : sh % (32'd1 << (8 * nb));
    lat    = bad ? 1 : 2 + rdy_dly + (tmo ? TO : rsp_dly + 1);
    if (is_lsu) begin
      bus.lsu_reqValid = 1'b1; bus.lsu_addr = addr; bus.lsu_size = size; bus.lsu_wen = wen;
      bus.lsu_wdata = wdata; bus.lsu_wmask = wm;
      if (!keep_other) bus.ifu_reqValid = 1'b0;
    end else begin
      bus.ifu_reqValid = 1'b1; bus.ifu_addr = addr;
      if (!keep_other) bus.lsu_reqValid = 1'b0;
    end
    done = 0; hs = 0; req_seen = 0; rdy_drv = 0; reqc = 0; waitc = 0; memreqs = 0;
    for (int k = 1; k <= 60 && !done; k++) begin
      @(posedge clock);
      @(negedge clock);
      if (req_seen && rdy_drv) begin hs = 1; req_seen = 0; end
      bus.mem_respValid = 1'b0; bus.mem_reqReady = 1'b0; bus.mem_rdata = $urandom;
      if (is_lsu) begin
        bus.lsu_addr = $urandom; bus.lsu_size = 2'($urandom); bus.lsu_wen = 1'($urandom);
        bus.lsu_wdata = $urandom; bus.lsu_wmask = 4'($urandom);
      end else bus.ifu_addr = $urandom;
      if (bus.ifu_respValid || bus.lsu_respValid) begin
        done = 1;
        check("latency", 32'(k), 32'(lat));
        check("resp_port", 32'({bus.ifu_respValid, bus.lsu_respValid}), is_lsu ? 32'd1 : 32'd2);
        check("rdata", is_lsu ? bus.lsu_rdata : bus.ifu_rdata, exp_rd);
        check("err", 32'(is_lsu ? bus.lsu_err : bus.ifu_err), 32'(bad || tmo));
        check("other_out", 32'(is_lsu ? (|bus.ifu_rdata || bus.ifu_err) : (|bus.lsu_rdata || bus.lsu_err)), 32'd0);
        check("mem_req_cycles", 32'(memreqs), bad ? 32'd0 : 32'(rdy_dly + 1));
        if (is_lsu) bus.lsu_reqValid = 1'b0; else bus.ifu_reqValid = 1'b0;
        if (tmo) bus.mem_respValid = 1'b1;
      end else if (bus.mem_reqValid) begin
        memreqs++;
        check("mem_addr", bus.mem_addr, {addr[31:2], 2'b00});
        check("mem_wen", 32'(bus.mem_wen), 32'(st));
        check("mem_wstrb", 32'(bus.mem_wstrb), 32'(strb));
        if (st) check("mem_wdata", bus.mem_wdata, wdata);
        req_seen = 1; rdy_drv = reqc == rdy_dly; bus.mem_reqReady = rdy_drv; reqc++;
      end else if (hs) begin
        bus.mem_respValid = waitc == rsp_dly;
        if (bus.mem_respValid) bus.mem_rdata = mrdata;
        waitc++;
      end
    end
    if (!done) check("resp_missing", 32'd0, 32'd1);
    @(posedge clock);
    @(negedge clock);
    bus.mem_respValid = 1'b0;
    check("resp_one_cycle", 32'({bus.ifu_respValid, bus.lsu_respValid, bus.mem_reqValid}), 32'd0);
  endtask

  logic [31:0] ra;
  logic [1:0]  rs;
  bit          rl, rw;

  initial begin
    bus.ifu_reqValid = 0; bus.ifu_addr = 0; bus.lsu_reqValid = 0; bus.lsu_addr = 0; bus.lsu_size = 0;
    bus.lsu_wen = 0; bus.lsu_wdata = 0; bus.lsu_wmask = 0; bus.mem_reqReady = 0; bus.mem_respValid = 0;
    bus.mem_rdata = 0;
    @(negedge clock);
    @(negedge clock);
    check("reset_flags", 32'({bus.ifu_respValid, bus.ifu_err, bus.lsu_respValid, bus.lsu_err,
                              bus.mem_reqValid, bus.mem_wen, bus.mem_wstrb}), 32'd0);
    check("reset_addr", bus.mem_addr, 32'd0);
    reset = 1'b1;
    @(negedge clock);
    txn(0, 0, 32'h80000004, 2'd2, 0, 32'h0, 32'h00100093, 0, 0);
    txn(1, 0, 32'h00001003, 2'd0, 0, 32'h0, 32'h8A000000, 0, 0);
    txn(1, 0, 32'h00001002, 2'd1, 0, 32'h0, 32'hBEEF1234, 1, 2);
    txn(1, 0, 32'h00002002, 2'd1, 1, 32'h56785678, 32'h11223344, 0, 1);
    txn(1, 0, 32'h00003001, 2'd2, 0, 32'h0, 32'hFFFFFFFF, 0, 0);
    txn(0, 0, 32'h00000102, 2'd2, 0, 32'h0, 32'hFFFFFFFF, 0, 0);
    txn(1, 0, 32'h00000400, 2'd3, 0, 32'h0, 32'hFFFFFFFF, 0, 0);
    bus.ifu_reqValid = 1'b1; bus.ifu_addr = 32'h00000100;
    txn(1, 1, 32'h00000500, 2'd2, 0, 32'h0, 32'hCAFEF00D, 5, 0);
    txn(0, 0, 32'h00000100, 2'd2, 0, 32'h0, 32'h00000013, 0, 0);
    txn(1, 0, 32'h00000600, 2'd2, 0, 32'h0, 32'h12345678, 0, 100);
    txn(1, 0, 32'h00000604, 2'd2, 0, 32'h0, 32'h9ABCDEF0, 0, TO - 1);
    bus.lsu_reqValid = 1'b1; bus.lsu_addr = 32'h00007004; bus.lsu_size = 2'd2; bus.lsu_wen = 1'b1;
    bus.lsu_wdata = 32'hA5A5A5A5; bus.lsu_wmask = 4'hF; bus.mem_reqReady = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check("rst_pre_req", 32'(bus.mem_reqValid), 32'd1);
    @(posedge clock);
    @(negedge clock);
    bus.mem_reqReady = 1'b0; bus.lsu_reqValid = 1'b0;
    check("rst_pre_addr", bus.mem_addr, 32'h00007004);
    #2 reset = 1'b0;
    #1;
    check("rst_addr", bus.mem_addr, 32'd0);
    check("rst_wdata", bus.mem_wdata, 32'd0);
    check("rst_flags", 32'({bus.ifu_respValid, bus.ifu_err, bus.lsu_respValid, bus.lsu_err,
                            bus.mem_reqValid, bus.mem_wen, bus.mem_wstrb}), 32'd0);
    @(negedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    bus.mem_respValid = 1'b1; bus.mem_rdata = 32'hDEADBEEF;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock);
      @(negedge clock);
      bus.mem_respValid = 1'b0;
      check("stray_after_reset", 32'({bus.ifu_respValid, bus.lsu_respValid, bus.mem_reqValid}), 32'd0);
    end
    for (int n = 0; n < 150; n++) begin
      rl = $urandom_range(0, 2) != 0;
      ra = $urandom;
      if ($urandom_range(0, 1) == 1) ra[1:0] = 2'b00;
      rs = 2'($urandom_range(0, 3));
      rw = 1'($urandom);
      txn(rl, 0, ra, rs, rw, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 5));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
